// File: rtl/mini_core_pipe_ctrl_if.sv
// Signal bundle between the mini_core datapath/decoder (master) and the
// pipeline controller (slave).
interface mini_core_pipe_ctrl_if #(
   parameter int NUM_STAGES = 5,
   parameter int REG_AW     = 5
);
   logic                  fetch_valid;
   logic [REG_AW-1:0]     dec_rs1;
   logic [REG_AW-1:0]     dec_rs2;
   logic                  dec_use_rs1;
   logic                  dec_use_rs2;
   logic [REG_AW-1:0]     exe_rd;
   logic                  exe_is_load;
   logic                  branch_taken;
   logic                  mem_req;
   logic                  mem_is_rd;
   logic                  dmem_ready;
   logic                  dmem_rd_rsp_valid;
   logic [NUM_STAGES-1:0] ready;
   logic [NUM_STAGES-1:0] valid;
   logic [NUM_STAGES-1:0] flush;
   logic                  load_hzrd;
   logic                  dmem_tmo;
   logic [31:0]           perf_cycles;
   logic [31:0]           perf_retired;
   logic [31:0]           perf_stalls;
   logic [31:0]           perf_flushes;

   modport master (
      output fetch_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             exe_rd, exe_is_load, branch_taken, mem_req, mem_is_rd,
             dmem_ready, dmem_rd_rsp_valid,
      input  ready, valid, flush, load_hzrd, dmem_tmo,
             perf_cycles, perf_retired, perf_stalls, perf_flushes
   );

   modport slave (
      input  fetch_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2,
             exe_rd, exe_is_load, branch_taken, mem_req, mem_is_rd,
             dmem_ready, dmem_rd_rsp_valid,
      output ready, valid, flush, load_hzrd, dmem_tmo,
             perf_cycles, perf_retired, perf_stalls, perf_flushes
   );
endinterface

// File: rtl/mini_core_pipe_ctrl.sv
// Pipeline control for mini_core: per-stage valid/ready/flush, load-use interlock and
// D_MEM request/response tracking with timeout. MINI_CORE_PERF_CNT_EN adds perf counters.
module mini_core_pipe_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int BR_STAGE   = 2,
   parameter int MEM_STAGE  = 3,
   parameter int REG_AW     = 5,
   parameter int DMEM_TMO   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   mini_core_pipe_ctrl_if.slave pif
);
   localparam int CW = $clog2(DMEM_TMO + 1);
   localparam logic [CW-1:0] TMO_MAX  = CW'(DMEM_TMO);
   localparam logic [CW-1:0] TMO_LAST = CW'(DMEM_TMO - 1);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RSP_WAIT = 1'b1} state_t;

   state_t                state_reg, state_next;
   logic [NUM_STAGES-1:1] valid_reg, valid_next;
   logic [CW-1:0]         wait_cnt_reg, wait_cnt_next;
   logic                  tmo_reg, tmo_next;
   logic [NUM_STAGES-1:0] valid_w, ready_w, flush_w;
   logic                  mem_stall, hzrd_raw, branch_flush, load_stall, load_accept;

   // Stage 0 always holds a fetch in flight once out of reset.
   assign valid_w = rst ? '0 : {valid_reg, 1'b1};

   always_comb begin
      mem_stall = 1'b0;
      if (!rst) begin
         if (state_reg == ST_IDLE)
            mem_stall = valid_w[MEM_STAGE] & pif.mem_req & ~pif.dmem_ready;
         else
            mem_stall = ~pif.dmem_rd_rsp_valid;
      end
   end

   assign hzrd_raw = valid_w[BR_STAGE] & pif.exe_is_load & (pif.exe_rd != '0) &
                     ((pif.dec_use_rs1 & (pif.dec_rs1 == pif.exe_rd)) |
                      (pif.dec_use_rs2 & (pif.dec_rs2 == pif.exe_rd)));

   // Memory stall dominates; a branch flush makes the load-use stall pointless.
   assign branch_flush = pif.branch_taken & valid_w[BR_STAGE] & ~mem_stall;
   assign load_stall   = hzrd_raw & ~mem_stall & ~branch_flush;

   // A response in the acceptance cycle is a zero-wait load and needs no wait state.
   assign load_accept = valid_w[MEM_STAGE] & pif.mem_req & pif.mem_is_rd &
                        pif.dmem_ready & ~pif.dmem_rd_rsp_valid;

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign ready_w[gi] = ~((mem_stall & (gi <= MEM_STAGE)) | (load_stall & (gi <= 1)));
      assign flush_w[gi] = branch_flush & (gi >= 1) & (gi <= BR_STAGE);
   end

   for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_valid
      logic src;
      logic bubble;
      if (gi == 1) begin : g_first
         assign src = pif.fetch_valid;
      end else begin : g_rest
         assign src = valid_w[gi-1];
      end
      assign bubble = flush_w[gi] | (mem_stall & (gi == MEM_STAGE + 1)) |
                      (load_stall & (gi == 2));
      assign valid_next[gi] = ready_w[gi] ? (src & ~bubble) : valid_reg[gi];
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = '0;
      tmo_next      = tmo_reg;
      case (state_reg)
         ST_IDLE:     if (load_accept) state_next = ST_RSP_WAIT;
         ST_RSP_WAIT: if (pif.dmem_rd_rsp_valid) state_next = ST_IDLE;
         default:     state_next = ST_IDLE;
      endcase
      // Counter saturates so the sticky flag cannot be missed by a wrap.
      if (mem_stall) begin
         wait_cnt_next = (wait_cnt_reg == TMO_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
         if (wait_cnt_reg >= TMO_LAST) tmo_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         valid_reg    <= '0;
         wait_cnt_reg <= '0;
         tmo_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         valid_reg    <= valid_next;
         wait_cnt_reg <= wait_cnt_next;
         tmo_reg      <= tmo_next;
      end
   end

   assign pif.ready     = ready_w;
   assign pif.valid     = valid_w;
   assign pif.flush     = flush_w;
   assign pif.load_hzrd = load_stall;
   assign pif.dmem_tmo  = tmo_reg;

`ifdef MINI_CORE_PERF_CNT_EN
   logic [31:0] cyc_reg, ret_reg, stl_reg, fl_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_reg <= '0;
         ret_reg <= '0;
         stl_reg <= '0;
         fl_reg  <= '0;
      end else begin
         cyc_reg <= cyc_reg + 32'd1;
         ret_reg <= ret_reg + 32'(valid_w[NUM_STAGES-1]);
         stl_reg <= stl_reg + 32'(mem_stall | load_stall);
         fl_reg  <= fl_reg + 32'(branch_flush);
      end
   end

   assign pif.perf_cycles  = cyc_reg;
   assign pif.perf_retired = ret_reg;
   assign pif.perf_stalls  = stl_reg;
   assign pif.perf_flushes = fl_reg;
`else
   assign pif.perf_cycles  = '0;
   assign pif.perf_retired = '0;
   assign pif.perf_stalls  = '0;
   assign pif.perf_flushes = '0;
`endif
endmodule

// File: tb/tb_mini_core_pipe_ctrl.sv
// Self-checking bench for mini_core_pipe_ctrl: directed scenarios plus random traffic
// compared against a stage-occupancy model.
module tb_mini_core_pipe_ctrl;
   localparam int NS  = 5;
   localparam int BR  = 2;
   localparam int MEM = 3;
   localparam int AW  = 5;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mini_core_pipe_ctrl_if #(.NUM_STAGES(NS), .REG_AW(AW)) pif ();

   mini_core_pipe_ctrl #(
      .NUM_STAGES(NS), .BR_STAGE(BR), .MEM_STAGE(MEM), .REG_AW(AW), .DMEM_TMO(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pif(pif.slave)
   );

   int total = 0;
   int bad   = 0;

   // Model: occupancy of each stage, whether a load response is owed, stall run length.
   bit          mv[NS];
   bit          m_wait, m_tmo;
   int          m_cnt;
   logic [31:0] m_cyc, m_ret, m_stl, m_fl;

   logic [NS-1:0] exp_ready, exp_flush, exp_valid;
   logic          exp_hz, exp_tmo;
   logic [127:0]  exp_perf;
   bit            e_stall, e_br;

   function automatic void model_eval();
      bit hz;
      exp_valid = '0;
      exp_ready = '1;
      exp_flush = '0;
      exp_hz    = 1'b0;
      exp_tmo   = m_tmo;
      e_stall   = 1'b0;
      e_br      = 1'b0;
`ifdef MINI_CORE_PERF_CNT_EN
      exp_perf = {m_cyc, m_ret, m_stl, m_fl};
`else
      exp_perf = '0;
`endif
      if (rst) return;
      exp_valid[0] = 1'b1;
      for (int i = 1; i < NS; i++) exp_valid[i] = mv[i];
      e_stall = (!m_wait && mv[MEM] && pif.mem_req && !pif.dmem_ready) ||
                (m_wait && !pif.dmem_rd_rsp_valid);
      hz = mv[BR] && pif.exe_is_load && (pif.exe_rd != 0) &&
           ((pif.dec_use_rs1 && pif.dec_rs1 == pif.exe_rd) ||
            (pif.dec_use_rs2 && pif.dec_rs2 == pif.exe_rd));
      e_br   = pif.branch_taken && mv[BR] && !e_stall;
      exp_hz = hz && !e_stall && !e_br;
      for (int i = 0; i < NS; i++) begin
         if (e_stall && i <= MEM) exp_ready[i] = 1'b0;
         if (exp_hz && i <= 1)    exp_ready[i] = 1'b0;
         if (e_br && i >= 1 && i <= BR) exp_flush[i] = 1'b1;
      end
   endfunction

   function automatic void model_tick();
      bit old_mem, old_last;
      if (rst) begin
         mv = '{default: 1'b0};
         m_wait = 1'b0; m_tmo = 1'b0; m_cnt = 0;
         m_cyc = '0; m_ret = '0; m_stl = '0; m_fl = '0;
         return;
      end
      old_mem  = mv[MEM];
      old_last = mv[NS-1];
      m_cyc = m_cyc + 32'd1;
      m_ret = m_ret + 32'(old_last);
      m_stl = m_stl + 32'(e_stall || exp_hz);
      m_fl  = m_fl + 32'(e_br);
      if (e_stall) begin
         m_cnt++;
         if (m_cnt >= TMO) m_tmo = 1'b1;
      end else begin
         m_cnt = 0;
      end
      if (!m_wait)
         m_wait = old_mem && pif.mem_req && pif.mem_is_rd && pif.dmem_ready && !pif.dmem_rd_rsp_valid;
      else if (pif.dmem_rd_rsp_valid)
         m_wait = 1'b0;
      if (e_stall) begin
         // Frozen front half; a hole opens right behind the memory stage.
         for (int i = NS - 1; i >= MEM + 2; i--) mv[i] = mv[i-1];
         mv[MEM+1] = 1'b0;
      end else if (exp_hz) begin
         for (int i = NS - 1; i >= 3; i--) mv[i] = mv[i-1];
         mv[2] = 1'b0;
      end else begin
         for (int i = NS - 1; i >= 2; i--) mv[i] = mv[i-1];
         mv[1] = pif.fetch_valid;
         if (e_br) for (int i = 1; i <= BR; i++) mv[i] = 1'b0;
      end
   endfunction

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic advance();
      model_tick();
      @(negedge clk);
   endtask

   task automatic fill(input int n);
      repeat (n) begin
         settle();
         advance();
      end
   endtask

   task automatic idle_inputs();
      pif.fetch_valid = 1'b0;
      pif.dec_rs1 = '0; pif.dec_rs2 = '0;
      pif.dec_use_rs1 = 1'b0; pif.dec_use_rs2 = 1'b0;
      pif.exe_rd = '0; pif.exe_is_load = 1'b0;
      pif.branch_taken = 1'b0;
      pif.mem_req = 1'b0; pif.mem_is_rd = 1'b0;
      pif.dmem_ready = 1'b1; pif.dmem_rd_rsp_valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if (pif.ready !== 5'b11111 || pif.flush !== 5'b00000) begin
            bad++; $display("FAIL reset_ready_flush got=%b/%b exp=11111/00000", pif.ready, pif.flush);
         end
         total++;
         if (pif.valid !== 5'b00000 || pif.load_hzrd !== 1'b0) begin
            bad++; $display("FAIL reset_valid got=%b hz=%b exp=00000 hz=0", pif.valid, pif.load_hzrd);
         end
         advance();
      end
      rst = 1'b0;
      pif.fetch_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         settle();
         if (c == 0) begin
            total++;
            if ({pif.perf_cycles, pif.perf_retired, pif.perf_stalls, pif.perf_flushes} !== '0 || pif.dmem_tmo !== 1'b0) begin
               bad++; $display("FAIL reset_counters got cyc=%0d tmo=%b exp=0", pif.perf_cycles, pif.dmem_tmo);
            end
         end
         total++;
         if (pif.valid !== exp_valid || pif.ready !== 5'b11111) begin
            bad++; $display("FAIL fill c=%0d got valid=%b ready=%b exp valid=%b ready=11111", c, pif.valid, pif.ready, exp_valid);
         end
         if (c == 4) begin
            total++;
            if (pif.valid !== 5'b11111) begin
               bad++; $display("FAIL fill_full got=%b exp=11111", pif.valid);
            end
         end
         advance();
      end
      $display("test_reset done");
   endtask

   task automatic test_load_hazard();
      idle_inputs();
      pif.fetch_valid = 1'b1;
      fill(3);
      pif.exe_is_load = 1'b1; pif.exe_rd = 5'd5;
      pif.dec_rs1 = 5'd5; pif.dec_use_rs1 = 1'b1;
      settle();
      total++;
      if (pif.load_hzrd !== 1'b1 || pif.ready !== 5'b11100) begin
         bad++; $display("FAIL hazard_stall got hz=%b ready=%b exp hz=1 ready=11100", pif.load_hzrd, pif.ready);
      end
      advance();
      settle();
      total++;
      if (pif.load_hzrd !== 1'b0 || pif.valid[2] !== 1'b0 || pif.valid !== exp_valid) begin
         bad++; $display("FAIL hazard_bubble got hz=%b valid=%b exp hz=0 valid=%b", pif.load_hzrd, pif.valid, exp_valid);
      end
      advance();
      pif.exe_rd = 5'd0; pif.dec_rs1 = 5'd0;
      settle();
      total++;
      if (pif.load_hzrd !== 1'b0 || pif.valid[2] !== 1'b1 || pif.ready !== 5'b11111) begin
         bad++; $display("FAIL hazard_rd0 got hz=%b valid=%b ready=%b exp hz=0 v2=1 ready=11111", pif.load_hzrd, pif.valid, pif.ready);
      end
      advance();
      for (int c = 0; c < 40; c++) begin
         pif.exe_is_load = 1'($urandom_range(0, 1));
         pif.exe_rd  = 5'($urandom_range(0, 3));
         pif.dec_rs1 = 5'($urandom_range(0, 3));
         pif.dec_rs2 = 5'($urandom_range(0, 3));
         pif.dec_use_rs1 = 1'($urandom_range(0, 1));
         pif.dec_use_rs2 = 1'($urandom_range(0, 1));
         settle();
         total++;
         if (pif.load_hzrd !== exp_hz || pif.ready !== exp_ready || pif.valid !== exp_valid) begin
            bad++; $display("FAIL hazard_rand c=%0d got hz=%b rdy=%b v=%b exp hz=%b rdy=%b v=%b",
                            c, pif.load_hzrd, pif.ready, pif.valid, exp_hz, exp_ready, exp_valid);
         end
         advance();
      end
      $display("test_load_hazard done");
   endtask

   task automatic test_branch();
      logic [31:0] fl0, fl_exp;
      idle_inputs();
      pif.fetch_valid = 1'b1;
      fill(4);
      fl0 = m_fl;
      pif.branch_taken = 1'b1;
      settle();
      total++;
      if (pif.flush !== 5'b00110 || pif.flush !== exp_flush || pif.ready !== 5'b11111) begin
         bad++; $display("FAIL branch_flush got flush=%b ready=%b exp flush=00110 ready=11111", pif.flush, pif.ready);
      end
      advance();
      pif.branch_taken = 1'b0;
      settle();
`ifdef MINI_CORE_PERF_CNT_EN
      fl_exp = fl0 + 32'd1;
`else
      fl_exp = '0;
`endif
      total++;
      if (pif.valid[2:1] !== 2'b00 || pif.valid !== exp_valid || pif.flush !== 5'b00000) begin
         bad++; $display("FAIL branch_bubble got valid=%b flush=%b exp valid=%b flush=00000", pif.valid, pif.flush, exp_valid);
      end
      total++;
      if (pif.perf_flushes !== fl_exp) begin
         bad++; $display("FAIL branch_perf got=%0d exp=%0d", pif.perf_flushes, fl_exp);
      end
      advance();
      $display("test_branch done");
   endtask

   task automatic test_mem_stall();
      logic [31:0] stl0, stl_exp;
      int stalls_seen;
      idle_inputs();
      pif.fetch_valid = 1'b1;
      fill(5);
      stl0 = m_stl;
      stalls_seen = 0;
      pif.mem_req = 1'b1; pif.mem_is_rd = 1'b1; pif.dmem_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if (pif.ready !== 5'b10000 || pif.flush !== 5'b00000 || pif.valid !== exp_valid ||
             (c > 0 && pif.valid[4] !== 1'b0)) begin
            bad++; $display("FAIL mem_notready c=%0d got ready=%b valid=%b exp ready=10000 valid=%b", c, pif.ready, pif.valid, exp_valid);
         end
         if (pif.ready[0] === 1'b0) stalls_seen++;
         advance();
      end
      pif.dmem_ready = 1'b1;
      settle();
      total++;
      if (pif.ready !== 5'b11111) begin
         bad++; $display("FAIL mem_accept got ready=%b exp=11111", pif.ready);
      end
      advance();
      pif.mem_req = 1'b0;
      for (int c = 0; c < 4; c++) begin
         pif.dmem_rd_rsp_valid = (c == 3);
         settle();
         total++;
         if (pif.ready !== exp_ready || pif.valid !== exp_valid || pif.ready !== ((c == 3) ? 5'b11111 : 5'b10000)) begin
            bad++; $display("FAIL mem_rspwait c=%0d got ready=%b valid=%b exp ready=%b valid=%b", c, pif.ready, pif.valid, exp_ready, exp_valid);
         end
         if (pif.ready[0] === 1'b0) stalls_seen++;
         advance();
      end
      pif.dmem_rd_rsp_valid = 1'b0;
      settle();
      total++;
      if (stalls_seen != 6) begin
         bad++; $display("FAIL mem_stall_len got=%0d exp=6", stalls_seen);
      end
`ifdef MINI_CORE_PERF_CNT_EN
      stl_exp = stl0 + 32'd6;
`else
      stl_exp = '0;
`endif
      total++;
      if (pif.perf_stalls !== stl_exp) begin
         bad++; $display("FAIL mem_perf_stalls got=%0d exp=%0d", pif.perf_stalls, stl_exp);
      end
      advance();
      $display("test_mem_stall done");
   endtask

   task automatic test_timeout();
      idle_inputs();
      pif.fetch_valid = 1'b1;
      fill(3);
      pif.mem_req = 1'b1; pif.mem_is_rd = 1'b1;
      settle();
      advance();
      pif.mem_req = 1'b0;
      for (int j = 0; j < 70; j++) begin
         settle();
         total++;
         if (pif.dmem_tmo !== exp_tmo || pif.ready !== 5'b10000) begin
            bad++; $display("FAIL tmo_wait j=%0d got tmo=%b ready=%b exp tmo=%b ready=10000", j, pif.dmem_tmo, pif.ready, exp_tmo);
         end
         if (j == 63 || j == 64) begin
            total++;
            if (pif.dmem_tmo !== 1'(j == 64)) begin
               bad++; $display("FAIL tmo_edge j=%0d got=%b exp=%b", j, pif.dmem_tmo, (j == 64));
            end
         end
         advance();
      end
      rst = 1'b1;
      settle();
      total++;
      if (pif.ready !== 5'b11111 || pif.flush !== 5'b00000 || pif.valid !== 5'b00000) begin
         bad++; $display("FAIL tmo_reset got ready=%b flush=%b valid=%b exp 11111/00000/00000", pif.ready, pif.flush, pif.valid);
      end
      advance();
      rst = 1'b0;
      settle();
      total++;
      if (pif.dmem_tmo !== 1'b0 || pif.ready !== 5'b11111) begin
         bad++; $display("FAIL tmo_cleared got tmo=%b ready=%b exp tmo=0 ready=11111", pif.dmem_tmo, pif.ready);
      end
      advance();
      $display("test_timeout done");
   endtask

   task automatic test_branch_during_stall();
      idle_inputs();
      pif.fetch_valid = 1'b1;
      fill(5);
      pif.mem_req = 1'b1; pif.mem_is_rd = 1'b1; pif.dmem_ready = 1'b0;
      pif.branch_taken = 1'b1;
      for (int c = 0; c < 3; c++) begin
         settle();
         total++;
         if (pif.flush !== 5'b00000 || pif.ready !== 5'b10000) begin
            bad++; $display("FAIL brstall_hold c=%0d got flush=%b ready=%b exp 00000/10000", c, pif.flush, pif.ready);
         end
         advance();
      end
      pif.dmem_ready = 1'b1;
      settle();
      total++;
      if (pif.flush !== 5'b00110 || pif.flush !== exp_flush || pif.ready !== 5'b11111) begin
         bad++; $display("FAIL brstall_release got flush=%b ready=%b exp 00110/11111", pif.flush, pif.ready);
      end
      advance();
      pif.branch_taken = 1'b0; pif.mem_req = 1'b0;
      settle();
      total++;
      if (pif.flush !== 5'b00000 || pif.valid !== exp_valid || pif.ready !== 5'b10000) begin
         bad++; $display("FAIL brstall_after got flush=%b valid=%b ready=%b exp 00000/%b/10000", pif.flush, pif.valid, pif.ready, exp_valid);
      end
      advance();
      pif.dmem_rd_rsp_valid = 1'b1;
      settle();
      advance();
      pif.dmem_rd_rsp_valid = 1'b0;
      $display("test_branch_during_stall done");
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         pif.fetch_valid  = 1'($urandom_range(0, 1));
         pif.dec_rs1      = 5'($urandom_range(0, 3));
         pif.dec_rs2      = 5'($urandom_range(0, 3));
         pif.dec_use_rs1  = 1'($urandom_range(0, 1));
         pif.dec_use_rs2  = 1'($urandom_range(0, 1));
         pif.exe_rd       = 5'($urandom_range(0, 3));
         pif.exe_is_load  = ($urandom_range(0, 2) == 0);
         pif.branch_taken = ($urandom_range(0, 9) == 0);
         pif.mem_req      = ($urandom_range(0, 3) == 0);
         pif.mem_is_rd    = 1'($urandom_range(0, 1));
         pif.dmem_ready   = ($urandom_range(0, 3) != 0);
         pif.dmem_rd_rsp_valid = ($urandom_range(0, 2) == 0);
         settle();
         total++;
         if (pif.ready !== exp_ready || pif.valid !== exp_valid || pif.flush !== exp_flush ||
             pif.load_hzrd !== exp_hz || pif.dmem_tmo !== exp_tmo) begin
            bad++; $display("FAIL random c=%0d got rdy=%b v=%b fl=%b hz=%b tmo=%b exp rdy=%b v=%b fl=%b hz=%b tmo=%b",
                            c, pif.ready, pif.valid, pif.flush, pif.load_hzrd, pif.dmem_tmo,
                            exp_ready, exp_valid, exp_flush, exp_hz, exp_tmo);
         end
         total++;
         if ({pif.perf_cycles, pif.perf_retired, pif.perf_stalls, pif.perf_flushes} !== exp_perf) begin
            bad++; $display("FAIL random_perf c=%0d got=%h exp=%h", c,
                            {pif.perf_cycles, pif.perf_retired, pif.perf_stalls, pif.perf_flushes}, exp_perf);
         end
         advance();
      end
      rst = 1'b0;
      $display("test_random done");
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_load_hazard();
      test_branch();
      test_mem_stall();
      test_timeout();
      test_branch_during_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
